mips_mdu: RTL and testbench

- Iterative multiply/divide unit with its own HI/LO registers for the multi-cycle MIPS core.
- Executes MULT, MULTU, DIV and DIVU at one result bit per clock; also executes MTHI and MTLO.
- The control FSM issues operations through a start/busy/done handshake and stalls the core while `busy_o` is high.
- Operand width is parametrised; signed support can be disabled.

---
 rtl/mips_mdu_if.sv | 26 ++
 rtl/mips_mdu.sv | 162 ++++++++++++++++
 tb/tb_mips_mdu.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mips_mdu_if.sv
// Issue/result bundle between the core control FSM and the multiply/divide unit.
// The master side issues operations; the slave side (the MDU) reports status and HI/LO.
interface mips_mdu_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic [2:0]       op_i;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             abort_i;
   logic             busy_o;
   logic             done_o;
   logic             dz_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output start_i, op_i, a_i, b_i, abort_i,
      input  busy_o, done_o, dz_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, op_i, a_i, b_i, abort_i,
      output busy_o, done_o, dz_o, hi_o, lo_o
   );
endinterface

// File: rtl/mips_mdu.sv
// Iterative MIPS multiply/divide unit with private HI/LO registers.
// Produces one result bit per clock; signed ops run on magnitudes and are sign-fixed at the end.
module mips_mdu #(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic      clk,
   input  logic      reset,
   mips_mdu_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opB;
   logic [WIDTH-1:0]   r_aRaw;
   logic               r_isDiv;
   logic               r_negRes;
   logic               r_negRem;
   logic               r_divZero;
   logic               r_dz;
   logic               r_dzSaved;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_signedOp;
   logic [WIDTH-1:0]   w_aAbs;
   logic [WIDTH-1:0]   w_bAbs;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_mulNext;
   logic [WIDTH:0]     w_remShift;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_divNext;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;

   always_comb begin
      w_signedOp = SIGNED_EN && ((bus.op_i == OP_MULT) || (bus.op_i == OP_DIV));
      w_aAbs     = (w_signedOp && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
      w_bAbs     = (w_signedOp && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;

      // Multiply: high half accumulates, low half holds the multiplier shifting out LSB-first.
      w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opB};
      w_mulNext  = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

      // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
      w_remShift = r_acc[2*WIDTH-1:WIDTH-1];
      w_diff     = w_remShift - {1'b0, r_opB};
      w_divNext  = w_diff[WIDTH] ? {w_remShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                 : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

      w_prod     = r_negRes ? -r_acc : r_acc;
      w_quot     = r_negRes ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_rem      = r_negRem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
   end

   // Control FSM plus datapath registers; abort restores the dz flag saved at issue.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_opB     <= '0;
         r_aRaw    <= '0;
         r_isDiv   <= 1'b0;
         r_negRes  <= 1'b0;
         r_negRem  <= 1'b0;
         r_divZero <= 1'b0;
         r_dz      <= 1'b0;
         r_dzSaved <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start_i) begin
                  case (bus.op_i)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        r_isDiv   <= bus.op_i[1];
                        r_opB     <= bus.op_i[1] ? w_bAbs : w_aAbs;
                        r_acc     <= bus.op_i[1] ? {{WIDTH{1'b0}}, w_aAbs}
                                                 : {{WIDTH{1'b0}}, w_bAbs};
                        r_aRaw    <= bus.a_i;
                        r_divZero <= (bus.b_i == '0);
                        r_negRes  <= w_signedOp && (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
                        r_negRem  <= w_signedOp && bus.a_i[WIDTH-1];
                        r_dzSaved <= r_dz;
                        r_dz      <= 1'b0;
                        r_cnt     <= CW'(WIDTH);
                        r_busy    <= 1'b1;
                        r_state   <= CALC;
                     end
                     OP_MTHI: r_hi <= bus.a_i;
                     OP_MTLO: r_lo <= bus.a_i;
                     default: ;
                  endcase
               end
            end
            CALC: begin
               if (bus.abort_i) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
                  r_dz    <= r_dzSaved;
               end else begin
                  r_acc <= r_isDiv ? w_divNext : w_mulNext;
                  r_cnt <= r_cnt - CW'(1);
                  if (r_cnt == CW'(1)) r_state <= FIX;
               end
            end
            FIX: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_cnt   <= '0;
               if (bus.abort_i) begin
                  r_dz <= r_dzSaved;
               end else begin
                  r_done <= 1'b1;
                  if (!r_isDiv) begin
                     r_hi <= w_prod[2*WIDTH-1:WIDTH];
                     r_lo <= w_prod[WIDTH-1:0];
                  end else if (r_divZero) begin
                     r_hi <= r_aRaw;
                     r_lo <= '1;
                     r_dz <= 1'b1;
                  end else begin
                     r_hi <= w_rem;
                     r_lo <= w_quot;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy_o = r_busy;
   assign bus.done_o = r_done;
   assign bus.dz_o   = r_dz;
   assign bus.hi_o   = r_hi;
   assign bus.lo_o   = r_lo;
endmodule

// File: tb/tb_mips_mdu.sv
// Directed bench for mips_mdu: hand-computed mult/div results, handshake, abort and reset corners.
module tb_mips_mdu;
   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   cycles;
   int   doneSeen;

   mips_mdu_if #(.WIDTH(32)) bus ();

   mips_mdu #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running clock; inputs change and outputs are sampled on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one mult/div and wait (bounded) for done; cycles = edges from the sampling edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i    = op;
      bus.a_i     = a;
      bus.b_i     = b;
      @(negedge clk);
      bus.start_i = 1'b0;
      cycles = 0;
      while (bus.done_o !== 1'b1 && cycles < 60) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      bus.start_i = 1'b0;
      bus.op_i    = 3'b000;
      bus.a_i     = '0;
      bus.b_i     = '0;
      bus.abort_i = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_status", {61'd0, bus.busy_o, bus.done_o, bus.dz_o}, 64'd0);
      checkOutput("reset_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
      reset = 1'b1;

      applyStimulus(3'b000, 32'hFFFF_FFFD, 32'd7);
      checkOutput("mult_latency", 64'(cycles), 64'd33);
      checkOutput("mult_hilo", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
      @(negedge clk);
      checkOutput("done_one_cycle", {63'd0, bus.done_o}, 64'd0);

      applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checkOutput("multu_hilo", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFE_0000_0001);

      applyStimulus(3'b010, 32'hFFFF_FFF9, 32'd2);
      checkOutput("div_hilo", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);

      applyStimulus(3'b011, 32'd100, 32'd7);
      checkOutput("divu_latency", 64'(cycles), 64'd33);
      checkOutput("divu_hilo", {bus.hi_o, bus.lo_o}, 64'h0000_0002_0000_000E);

      applyStimulus(3'b011, 32'd5, 32'd0);
      checkOutput("divz_latency", 64'(cycles), 64'd33);
      checkOutput("divz_hilo", {bus.hi_o, bus.lo_o}, 64'h0000_0005_FFFF_FFFF);
      checkOutput("divz_flag", {63'd0, bus.dz_o}, 64'd1);

      // Abort ten cycles into a MULT: HI/LO and the previous dz flag must survive.
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i    = 3'b000;
      bus.a_i     = 32'd9;
      bus.b_i     = 32'd9;
      @(negedge clk);
      bus.start_i = 1'b0;
      checkOutput("mult_dz_cleared", {63'd0, bus.dz_o}, 64'd0);
      repeat (9) @(negedge clk);
      bus.abort_i = 1'b1;
      @(negedge clk);
      bus.abort_i = 1'b0;
      checkOutput("abort_busy", {63'd0, bus.busy_o}, 64'd0);
      doneSeen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done_o === 1'b1) doneSeen++;
      end
      checkOutput("abort_no_done", 64'(doneSeen), 64'd0);
      checkOutput("abort_hilo", {bus.hi_o, bus.lo_o}, 64'h0000_0005_FFFF_FFFF);
      checkOutput("abort_dz_kept", {63'd0, bus.dz_o}, 64'd1);

      applyStimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
      checkOutput("div_ovf_hilo", {bus.hi_o, bus.lo_o}, 64'h0000_0000_8000_0000);
      checkOutput("div_ovf_dz", {63'd0, bus.dz_o}, 64'd0);

      @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i    = 3'b100;
      bus.a_i     = 32'h1234_5678;
      @(negedge clk);
      bus.start_i = 1'b0;
      checkOutput("mthi_hilo", {bus.hi_o, bus.lo_o}, 64'h1234_5678_8000_0000);
      checkOutput("mthi_busy", {63'd0, bus.busy_o}, 64'd0);

      bus.start_i = 1'b1;
      bus.op_i    = 3'b101;
      bus.a_i     = 32'hCAFE_0001;
      @(negedge clk);
      bus.start_i = 1'b0;
      checkOutput("mtlo_hilo", {bus.hi_o, bus.lo_o}, 64'h1234_5678_CAFE_0001);

      bus.start_i = 1'b1;
      bus.op_i    = 3'b110;
      bus.a_i     = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.start_i = 1'b0;
      checkOutput("reserved_ignored", {bus.hi_o, bus.lo_o, 31'd0, bus.busy_o}, {64'h1234_5678_CAFE_0001, 32'd0});

      // A second start while busy must not disturb the MULTU in flight.
      bus.start_i = 1'b1;
      bus.op_i    = 3'b001;
      bus.a_i     = 32'd3;
      bus.b_i     = 32'd5;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (4) @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i    = 3'b011;
      bus.a_i     = 32'd77;
      bus.b_i     = 32'd4;
      @(negedge clk);
      bus.start_i = 1'b0;
      cycles = 5;
      while (bus.done_o !== 1'b1 && cycles < 60) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("busy_start_latency", 64'(cycles), 64'd33);
      checkOutput("busy_start_hilo", {bus.hi_o, bus.lo_o}, 64'h0000_0000_0000_000F);

      applyStimulus(3'b001, 32'd6, 32'd7);
      checkOutput("back_to_back_hilo", {bus.hi_o, bus.lo_o}, 64'h0000_0000_0000_002A);

      @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i    = 3'b010;
      bus.a_i     = 32'd1000;
      bus.b_i     = 32'd3;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("pre_reset_busy", {63'd0, bus.busy_o}, 64'd1);
      #2 reset = 1'b0;
      #1;
      checkOutput("mid_reset_status", {61'd0, bus.busy_o, bus.done_o, bus.dz_o}, 64'd0);
      checkOutput("mid_reset_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
